// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR BIST engine.
//   state_t        FSM state encoding (IDLE / RUN / DONE)
//   MODE_PRPG/MISR values of the mode input
//   POLY8/16/32    maximal-length Fibonacci tap masks (bit i set => q[i] feeds the XOR)
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_PRPG = 1'b0;
    localparam logic MODE_MISR = 1'b1;

    // x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1, x^32+x^22+x^2+x+1
    localparam logic [7:0]  POLY8  = 8'hB8;
    localparam logic [15:0] POLY16 = 16'hB400;
    localparam logic [31:0] POLY32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational next-state function of a W-bit Fibonacci LFSR/MISR.
//   q        current state
//   data_in  response word folded in when mode = MODE_MISR
//   mode     MODE_PRPG / MODE_MISR
//   q_next   state after one step
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int             W    = 8,
    parameter logic [W-1:0]   POLY = POLY8
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] data_in,
    input  logic         mode,
    output logic [W-1:0] q_next
);

    logic         fb;
    logic [W-1:0] m;

    always_comb begin
        fb     = ^(q & POLY);
        m      = (mode == MODE_MISR) ? data_in : '0;
        q_next = {q[W-2:0], fb} ^ m;
    end

endmodule

// File: rtl/lfsr_bist_engine.sv
// lfsr_bist_engine: W-bit LFSR used as pattern generator (PRPG) or signature
// register (MISR), running COUNT steps per start and holding the result.
//   CLK, RSTn      clock, asynchronous active-low reset
//   mode           0 = PRPG, 1 = MISR (sampled every step)
//   seed/seed_load load a seed while idle or done (zero PRPG seed is replaced)
//   start/abort    begin a run / terminate it without stepping
//   data_in        CUT response word for MISR compression
//   q              state / signature; serial_out = q[W-1], tap_out = q[OUT_TAP]
//   busy/done      running / run completed; zero_seed flags a sanitised seed
module lfsr_bist_engine
    import lfsr_pkg::*;
#(
    parameter int           W            = 8,
    parameter logic [W-1:0] POLY         = 8'hB8,
    parameter logic [W-1:0] SEED_DEFAULT = 8'h01,
    parameter int           COUNT        = 255,
    parameter int           OUT_TAP      = 3
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         mode,
    input  logic [W-1:0] seed,
    input  logic         seed_load,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] q,
    output logic         serial_out,
    output logic         tap_out,
    output logic         busy,
    output logic         done,
    output logic         zero_seed
);

    localparam int            CW   = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          start_pend;  // start that arrived together with seed_load
    logic [W-1:0]  q_next;

    lfsr_step #(.W(W), .POLY(POLY)) u_step (
        .q       (q),
        .data_in (data_in),
        .mode    (mode),
        .q_next  (q_next)
    );

    assign serial_out = q[W-1];
    assign tap_out    = q[OUT_TAP];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            start_pend <= 1'b0;
            q          <= SEED_DEFAULT;
            busy       <= 1'b0;
            done       <= 1'b0;
            zero_seed  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    // abort wins over terminal count and freezes q
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        q   <= q_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    start_pend <= 1'b0;
                    if (seed_load) begin
                        // a load leaves DONE so that done and state stay consistent
                        state      <= ST_IDLE;
                        done       <= 1'b0;
                        start_pend <= start;
                        if (mode == MODE_PRPG && seed == '0) begin
                            q         <= SEED_DEFAULT;
                            zero_seed <= 1'b1;
                        end else begin
                            q         <= seed;
                            zero_seed <= 1'b0;
                        end
                    end else if (start || start_pend) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_bist_engine.sv
module tb_lfsr_bist_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode, seed_load, start, abort;
    logic [7:0]  seed8, data8;
    logic [15:0] seed16, data16;

    logic [7:0]  qa, qb;
    logic [15:0] qc;
    logic        sa, ta, ba, da, za;
    logic        sb, tb, bb, db, zb;
    logic        sc, tc, bc, dc, zc;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lfsr_bist_engine #(.W(8), .POLY(8'hB8), .SEED_DEFAULT(8'h01), .COUNT(255), .OUT_TAP(3)) dut_a (
        .CLK(clk), .RSTn(rst_n), .mode(mode), .seed(seed8), .seed_load(seed_load),
        .start(start), .abort(abort), .data_in(data8), .q(qa), .serial_out(sa),
        .tap_out(ta), .busy(ba), .done(da), .zero_seed(za));

    lfsr_bist_engine #(.W(8), .POLY(8'hB8), .SEED_DEFAULT(8'h01), .COUNT(16), .OUT_TAP(3)) dut_b (
        .CLK(clk), .RSTn(rst_n), .mode(mode), .seed(seed8), .seed_load(seed_load),
        .start(start), .abort(abort), .data_in(data8), .q(qb), .serial_out(sb),
        .tap_out(tb), .busy(bb), .done(db), .zero_seed(zb));

    lfsr_bist_engine #(.W(16), .POLY(16'hB400), .SEED_DEFAULT(16'h0001), .COUNT(65535), .OUT_TAP(3)) dut_c (
        .CLK(clk), .RSTn(rst_n), .mode(mode), .seed(seed16), .seed_load(seed_load),
        .start(start), .abort(abort), .data_in(data16), .q(qc), .serial_out(sc),
        .tap_out(tc), .busy(bc), .done(dc), .zero_seed(zc));

    // Reference: shift left by one, new LSB is the parity of the tapped bits,
    // then fold in the response word in MISR mode.
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] d,
                                             input logic m, input int w, input logic [31:0] poly);
        logic [31:0] mask, n;
        mask = (32'h1 << w) - 32'h1;
        n    = ((s << 1) | 32'($countones(s & poly) % 2)) & mask;
        if (m) n = n ^ (d & mask);
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mode = 1'b0; seed_load = 1'b0; start = 1'b0; abort = 1'b0;
        seed8 = '0; data8 = '0; seed16 = '0; data16 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // COUNT=16 run on dut_b; per-step mode is random when mix is set
    task automatic run_b(input string name, input logic m0, input logic [7:0] sd,
                         input bit zero_data, input bit mix);
        logic [31:0] s;
        int derr, terr;
        do_reset();
        mode = m0; seed8 = sd; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk({name, "_zs"}, 32'(zb), 32'(m0 == 1'b0 && sd == 8'h00));
        start = 1'b1;
        tick();
        start = 1'b0;
        s = (m0 == 1'b0 && sd == 8'h00) ? 32'h01 : 32'(sd);
        derr = 0; terr = 0;
        for (int i = 0; i < 16; i++) begin
            data8 = zero_data ? 8'h00 : 8'($urandom);
            if (mix) mode = 1'($urandom);
            s = ref_step(s, 32'(data8), mode, 8, 32'hB8);
            tick();
            if (db !== (i == 15)) derr++;
            if (sb !== qb[7] || tb !== qb[3]) terr++;
        end
        chk({name, "_sig"}, 32'(qb), s);
        chk({name, "_done_timing"}, derr, 0);
        chk({name, "_taps"}, terr, 0);
    endtask

    typedef struct {
        logic md, ld, st, ab;
        logic [7:0] sd, dt, eq;
        logic eb, ed, ez;
    } vec_t;

    localparam int NV = 18;
    vec_t vt[NV];

    bit seen8[256];
    bit seen16[65536];

    initial begin
        logic [31:0] s;
        int errs, dup, zer, derr, terr;

        //          md    ld    st    ab    seed   data   q      busy  done  zs
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h23, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h47, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h47, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h47, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
        vt[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0};

        // reset values
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_q", 32'(qa), 32'h01);
        chk("rst_busy", 32'(ba), 32'h0);
        chk("rst_done", 32'(da), 32'h0);
        chk("rst_zs", 32'(za), 32'h0);
        chk("rst_q16", 32'(qc), 32'h0001);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors on dut_a
        for (int i = 0; i < NV; i++) begin
            mode = vt[i].md; seed_load = vt[i].ld; start = vt[i].st; abort = vt[i].ab;
            seed8 = vt[i].sd; data8 = vt[i].dt;
            tick();
            chk($sformatf("vec%0d_q", i), 32'(qa), 32'(vt[i].eq));
            chk($sformatf("vec%0d_busy", i), 32'(ba), 32'(vt[i].eb));
            chk($sformatf("vec%0d_done", i), 32'(da), 32'(vt[i].ed));
            chk($sformatf("vec%0d_zs", i), 32'(za), 32'(vt[i].ez));
            chk($sformatf("vec%0d_ser", i), 32'({sa, ta}), 32'({vt[i].eq[7], vt[i].eq[3]}));
        end
        idle_inputs();

        // full PRPG period on dut_a, COUNT = 255
        do_reset();
        seed8 = 8'h01; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("p8_busy", 32'(ba), 32'h1);
        s = 32'h01; errs = 0; dup = 0; zer = 0; derr = 0; terr = 0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            s = ref_step(s, 0, 1'b0, 8, 32'hB8);
            if (32'(qa) !== s) errs++;
            if (seen8[qa]) dup++;
            seen8[qa] = 1'b1;
            if (qa == 8'h00) zer++;
            if (da !== (i == 255)) derr++;
            if (sa !== qa[7] || ta !== qa[3]) terr++;
        end
        chk("p8_model", errs, 0);
        chk("p8_distinct", dup, 0);
        chk("p8_nonzero", zer, 0);
        chk("p8_done_timing", derr, 0);
        chk("p8_taps", terr, 0);
        chk("p8_final_q", 32'(qa), 32'h01);
        tick();
        tick();
        chk("p8_done_held", 32'({da, ba}), 32'b10);
        chk("p8_q_held", 32'(qa), 32'h01);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("p8_restart", 32'({da, ba}), 32'b01);

        // seed_load and start on the same edge
        do_reset();
        seed8 = 8'h5A; seed_load = 1'b1; start = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b0;
        chk("ls_load", 32'({qa, ba}), 32'({8'h5A, 1'b0}));
        tick();
        chk("ls_run", 32'({qa, ba}), 32'({8'h5A, 1'b1}));
        tick();
        chk("ls_step", 32'(qa), ref_step(32'h5A, 0, 1'b0, 8, 32'hB8));

        // abort after step 10 with a random seed
        do_reset();
        seed8 = 8'($urandom_range(1, 255)); seed_load = 1'b1;
        s = 32'(seed8);
        tick();
        seed_load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            s = ref_step(s, 0, 1'b0, 8, 32'hB8);
        end
        chk("ab_step10", 32'(qa), s);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_q", 32'(qa), s);
        chk("ab_flags", 32'({ba, da}), 32'b00);
        tick(); tick(); tick();
        chk("ab_held", 32'({qa, ba, da}), {s[29:0], 2'b00});

        // asynchronous reset mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_q", 32'(qa), 32'h01);
        chk("async_busy", 32'(ba), 32'h0);
        #1 rst_n = 1'b1;

        // COUNT = 16 runs on dut_b
        run_b("misr_zero", 1'b1, 8'h00, 1'b1, 1'b0);
        chk("misr_zero_q", 32'(qb), 32'h0);
        run_b("prpg_zseed", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int r = 0; r < 6; r++)
            run_b($sformatf("rnd%0d", r), 1'($urandom), 8'($urandom), 1'b0, (r % 2) == 1);

        // W = 16 full period on dut_c
        do_reset();
        seed16 = 16'h0001; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        s = 32'h0001; errs = 0; dup = 0; zer = 0; derr = 0; terr = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            s = ref_step(s, 0, 1'b0, 16, 32'hB400);
            if (32'(qc) !== s) errs++;
            if (seen16[qc]) dup++;
            seen16[qc] = 1'b1;
            if (qc == 16'h0000) zer++;
            if (dc !== (i == 65535)) derr++;
            if (sc !== qc[15] || tc !== qc[3]) terr++;
        end
        chk("p16_model", errs, 0);
        chk("p16_distinct", dup, 0);
        chk("p16_nonzero", zer, 0);
        chk("p16_done_timing", derr, 0);
        chk("p16_taps", terr, 0);
        chk("p16_final", 32'({qc, bc, zc}), 32'({16'h0001, 1'b0, 1'b0}));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
